// File: rtl/divider.sv
// Serial restoring divider: unsigned WIDTH-bit quotient and remainder, one quotient bit per clock.
// Uses the same start/busy/done handshake as the serial shift-add multiplier.
module divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             start,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   p_sh;
  logic [WIDTH-1:0] diff;
  logic             no_borrow;
  logic [WIDTH-1:0] p_nxt;
  logic [WIDTH-1:0] q_nxt;

  // The stored partial remainder is always below the divisor, so its extra
  // top bit only exists transiently in the shifted value p_sh.
  always_comb begin
    p_sh      = {p, q[WIDTH-1]};
    no_borrow = (p_sh >= {1'b0, dvs});
    diff      = p_sh[WIDTH-1:0] - dvs;
    p_nxt     = no_borrow ? diff : p_sh[WIDTH-1:0];
    q_nxt     = {q[WIDTH-2:0], no_borrow};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      p         <= '0;
      q         <= '0;
      dvs       <= '0;
      count     <= '0;
      out       <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            q     <= in1;
            dvs   <= in2;
            p     <= '0;
            count <= CW'(WIDTH);
            state <= RUN;
          end
        end
        RUN: begin
          p     <= p_nxt;
          q     <= q_nxt;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            out       <= q_nxt;
            remainder <= p_nxt;
            div_zero  <= (dvs == '0);
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_divider.sv
// Randomized self-checking bench for divider: a cycle-level reference model of the
// handshake plus plain-arithmetic results, with directed literal cases up front.
module tb_divider;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic         start = 1'b0;
  logic [W-1:0] out;
  logic [W-1:0] remainder;
  logic         div_zero;
  logic         busy;
  logic         done;

  divider #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in1(in1), .in2(in2), .start(start),
    .out(out), .remainder(remainder), .div_zero(div_zero), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference model: one operation at a time, result due WIDTH edges after acceptance,
  // next acceptance possible WIDTH+2 edges after the previous one.
  int           cyc = 0;
  int           next_free = 0;
  bit           pend = 0;
  int           acc = 0;
  int           due = 0;
  logic [W-1:0] ma, mb, mq, mr;
  bit           mz;
  logic [W-1:0] eo = '0, er = '0;
  bit           ez = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (reset) begin
      pend = 0; eo = '0; er = '0; ez = 0;
      next_free = cyc + 1;
    end else begin
      if (pend && cyc == due) begin eo = mq; er = mr; ez = mz; end
      if (pend && cyc == due + 1) pend = 0;
      if (cyc >= next_free && start) begin
        pend = 1; acc = cyc; due = cyc + W;
        ma = in1; mb = in2;
        if (in2 == 0) begin mq = '1; mr = in1; mz = 1; end
        else begin mq = in1 / in2; mr = in1 % in2; mz = 0; end
        next_free = cyc + W + 2;
      end
    end
  end

  // Compare process: every cycle, mid-period.
  bit streaming = 0;
  int last_done = 0;
  initial forever begin
    @(negedge clk);
    if (cyc > 0) begin
      chk("done", done, (pend && cyc == due));
      chk("busy", busy, (pend && cyc >= acc && cyc <= due));
      chk("out", out, eo);
      chk("remainder", remainder, er);
      chk("div_zero", div_zero, ez);
      if (done && pend && cyc == due && !mz) begin
        chk("invariant", 32'(out) * 32'(mb) + 32'(remainder), 32'(ma));
        chk("rem_lt_div", 32'(remainder < mb), 32'd1);
      end
      if (done && streaming) begin
        if (last_done > 0) chk("spacing", cyc - last_done, W + 2);
        last_done = cyc;
      end
    end
  end

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic [W-1:0] xq, input logic [W-1:0] xr,
                    input bit xz, input bit disturb);
    int lat;
    @(posedge clk); #1;
    in1 = a; in2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 60) begin
      @(posedge clk); lat++; #1;
      if (disturb && lat == 3) begin in1 = W'($urandom); in2 = W'($urandom); start = 1'b1; end
      if (disturb && lat == 4) start = 1'b0;
    end
    chk("latency", lat, W);
    chk("lit_out", out, xq);
    chk("lit_rem", remainder, xr);
    chk("lit_dz", div_zero, xz);
  endtask

  initial begin
    int n;
    int budget;
    int seen;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_out", out, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    op(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0);
    op(16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    op(16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0);
    op(16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b0);
    op(16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 1'b1);

    // Abort in RUN cycle 8
    @(posedge clk); #1;
    in1 = 16'd777; in2 = 16'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_out", out, 0);
    chk("abort_rem", remainder, 0);
    seen = 0;
    repeat (20) begin @(posedge clk); #1; if (done) seen++; end
    chk("abort_no_done", seen, 0);
    op(16'd1000, 16'd33, 16'd30, 16'd10, 1'b0, 1'b0);

    // Random stream with start held high
    @(posedge clk); #1;
    streaming = 1; last_done = 0;
    start = 1'b1;
    n = 0; budget = 0;
    while (n < 2000 && budget < 2000 * (W + 2) + 200) begin
      case ($urandom_range(0, 7))
        0: in2 = '0;
        1: in2 = 16'd1;
        2: in2 = '1;
        3: in2 = W'($urandom_range(1, 15));
        default: in2 = W'($urandom);
      endcase
      in1 = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
      @(posedge clk); budget++; #1;
      if (done) n++;
    end
    chk("stream_count", n, 2000);
    start = 1'b0;
    streaming = 0;
    repeat (W + 4) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
